sobel_frame_scheduler: RTL and testbench

//  Sequences one frame at a time from a line-buffered pixel source into the sobel sharpen pipeline.

---
 rtl/sobel_sched_pkg.sv | 27 ++
 rtl/sobel_out_monitor.sv | 52 +++++
 rtl/sobel_frame_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_sobel_frame_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_sched_pkg.sv
// Shared state encoding, counter widths and frame-size helpers for the sobel frame scheduler.
package sobel_sched_pkg;

    localparam int LINE_CNT_W = 12;
    localparam int PIX_CNT_W  = 12;
    localparam int TMR_W      = 16;
    localparam int OUT_CNT_W  = 20;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_WAITL = 3'd2;
    localparam logic [2:0] ST_LINE  = 3'd3;
    localparam logic [2:0] ST_HBLK  = 3'd4;
    localparam logic [2:0] ST_FLUSH = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [OUT_CNT_W-1:0] OUT_PIX_TOTAL = 20'd307200; // 640 x 480

    // Pixels per frame for an arbitrary geometry, truncated to the out_cnt width.
    function automatic logic [OUT_CNT_W-1:0] pix_total(input logic [PIX_CNT_W-1:0] h,
                                                       input logic [LINE_CNT_W-1:0] v);
        logic [PIX_CNT_W+LINE_CNT_W-1:0] prod;
        prod = h * v;
        return prod[OUT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_out_monitor.sv
// Counts processed pixels coming back from the sobel pipeline and runs the flush watchdog.
module sobel_out_monitor
    import sobel_sched_pkg::*;
#(
    parameter logic [OUT_CNT_W-1:0] PIX_TOTAL = OUT_PIX_TOTAL,
    parameter int                   FLUSH_TMO = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic frame_start,
    input  logic in_flush,
    input  logic post_img_href,
    output logic flush_ok,
    output logic flush_tmo
);

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(FLUSH_TMO - 1);

    logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [TMR_W-1:0]     tmo_cnt_q, tmo_cnt_d;

    // Next-state for the returned-pixel count (saturating) and the flush cycle counter.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (frame_start) begin
            out_cnt_d = '0;
        end else if (busy && post_img_href && (out_cnt_q != '1)) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        tmo_cnt_d = '0;
        if (in_flush) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign flush_ok  = (out_cnt_q == PIX_TOTAL);
    // Asserted on the last allowed FLUSH cycle so the FSM leaves after exactly FLUSH_TMO cycles.
    assign flush_tmo = in_flush && (tmo_cnt_q == TMO_LAST);

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame sequencer feeding the sobel sharpen pipeline from a line-buffered pixel source.
module sobel_frame_scheduler
    import sobel_sched_pkg::*;
#(
    parameter logic [PIX_CNT_W-1:0]  IMG_HDISP  = 12'd640,
    parameter logic [LINE_CNT_W-1:0] IMG_VDISP  = 12'd480,
    parameter int                    HBLANK     = 16,
    parameter int                    VSYNC_LEAD = 8,
    parameter int                    FLUSH_TMO  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont_mode,
    input  logic        err_clr,
    input  logic        src_line_avail,
    output logic        src_rd,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        per_img_vsync,
    output logic        per_img_href,
    output logic        per_img_clken,
    output logic [7:0]  per_img_gray,
    input  logic        post_img_href,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        underflow_err,
    output logic        timeout_err
);

    localparam logic [PIX_CNT_W-1:0]  HDISP_LAST = IMG_HDISP - 1'b1;
    localparam logic [LINE_CNT_W-1:0] VDISP_LAST = IMG_VDISP - 1'b1;
    localparam logic [TMR_W-1:0]      LEAD_LAST  = TMR_W'(VSYNC_LEAD - 1);
    localparam logic [TMR_W-1:0]      HBLK_LAST  = TMR_W'(HBLANK - 1);

    logic [2:0]            state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [PIX_CNT_W-1:0]  pix_q, pix_d;
    logic [LINE_CNT_W-1:0] line_q, line_d;
    logic                  vld_p1_q, vld_p1_d;
    logic                  href_q, href_d;
    logic [7:0]            gray_q, gray_d;
    logic                  vsync_q, vsync_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  uf_err_q, uf_err_d;
    logic                  tmo_err_q, tmo_err_d;
    logic                  tmo_set;
    logic                  uf_set;
    logic                  lead_entry;
    logic                  flush_ok;
    logic                  flush_tmo;

    // Frame FSM with the blanking timer and the pixel/line issue counters.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pix_d   = pix_q;
        line_d  = line_q;
        tmo_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEAD;
                    tmr_d   = LEAD_LAST;
                    line_d  = '0;
                end
            end
            ST_LEAD: begin
                if (tmr_q == '0) state_d = ST_WAITL;
                else             tmr_d   = tmr_q - 1'b1;
            end
            ST_WAITL: begin
                // A line is only started when it can be issued without a stall.
                if (src_line_avail) begin
                    state_d = ST_LINE;
                    pix_d   = '0;
                end
            end
            ST_LINE: begin
                if (pix_q == HDISP_LAST) begin
                    state_d = ST_HBLK;
                    tmr_d   = HBLK_LAST;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            ST_HBLK: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (line_q == VDISP_LAST) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_WAITL;
                    line_d  = line_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_ok) begin
                    state_d = ST_DONE;
                end else if (flush_tmo) begin
                    state_d = ST_DONE;
                    tmo_set = 1'b1;
                end
            end
            ST_DONE: begin
                if (cont_mode) begin
                    state_d = ST_LEAD;
                    tmr_d   = LEAD_LAST;
                    line_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel path, vsync, frame counter and sticky error flags.
    always_comb begin
        lead_entry  = (state_d == ST_LEAD) && (state_q != ST_LEAD);
        vld_p1_d    = src_rd;
        href_d      = vld_p1_q;
        gray_d      = (vld_p1_q && src_valid) ? src_data : 8'h00;
        uf_set      = vld_p1_q && !src_valid;
        vsync_d     = (state_d == ST_LEAD) || (state_d == ST_WAITL) ||
                      (state_d == ST_LINE) || (state_d == ST_HBLK);
        frame_cnt_d = frame_cnt_q;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        // A set event in the same cycle as err_clr keeps the flag set.
        uf_err_d  = uf_set  ? 1'b1 : (err_clr ? 1'b0 : uf_err_q);
        tmo_err_d = tmo_set ? 1'b1 : (err_clr ? 1'b0 : tmo_err_q);
    end

    // Control and output registers; everything returns to zero on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            pix_q       <= '0;
            line_q      <= '0;
            vld_p1_q    <= 1'b0;
            href_q      <= 1'b0;
            gray_q      <= 8'h00;
            vsync_q     <= 1'b0;
            frame_cnt_q <= '0;
            uf_err_q    <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            vld_p1_q    <= vld_p1_d;
            href_q      <= href_d;
            gray_q      <= gray_d;
            vsync_q     <= vsync_d;
            frame_cnt_q <= frame_cnt_d;
            uf_err_q    <= uf_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    sobel_out_monitor #(
        .PIX_TOTAL (pix_total(IMG_HDISP, IMG_VDISP)),
        .FLUSH_TMO (FLUSH_TMO)
    ) u_out_monitor (
        .clk           (clk),
        .rst           (rst),
        .busy          (busy),
        .frame_start   (lead_entry),
        .in_flush      (state_q == ST_FLUSH),
        .post_img_href (post_img_href),
        .flush_ok      (flush_ok),
        .flush_tmo     (flush_tmo)
    );

    assign src_rd        = (state_q == ST_LINE);
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_DONE);
    assign per_img_vsync = vsync_q;
    assign per_img_href  = href_q;
    assign per_img_clken = href_q;
    assign per_img_gray  = gray_q;
    assign frame_cnt     = frame_cnt_q;
    assign underflow_err = uf_err_q;
    assign timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Scoreboard bench for sobel_frame_scheduler with an 8x4 frame and a 20-cycle pipeline model.
module tb_sobel_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont_mode = 1'b0;
    logic        err_clr = 1'b0;
    logic        src_line_avail = 1'b1;
    logic        src_rd;
    logic [7:0]  src_data = 8'h00;
    logic        src_valid = 1'b0;
    logic        per_img_vsync;
    logic        per_img_href;
    logic        per_img_clken;
    logic [7:0]  per_img_gray;
    logic        post_img_href = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        underflow_err;
    logic        timeout_err;

    sobel_frame_scheduler #(
        .IMG_HDISP  (12'd8),
        .IMG_VDISP  (12'd4),
        .HBLANK     (2),
        .VSYNC_LEAD (3),
        .FLUSH_TMO  (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cont_mode      (cont_mode),
        .err_clr        (err_clr),
        .src_line_avail (src_line_avail),
        .src_rd         (src_rd),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .per_img_vsync  (per_img_vsync),
        .per_img_href   (per_img_href),
        .per_img_clken  (per_img_clken),
        .per_img_gray   (per_img_gray),
        .post_img_href  (post_img_href),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .underflow_err  (underflow_err),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  gray;
        int unsigned stamp;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          fpix = 0;
    int          drop_idx = -1;
    int          ret_limit = 32;
    int          ret_cnt = 0;
    logic [7:0]  seq = 8'h10;
    logic [19:0] pipe = '0;
    logic        vs_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Source model: answers each src_rd one cycle later and records the pixel expected 2 cycles after src_rd.
    always @(posedge clk) begin
        if (src_rd) begin
            if (fpix == drop_idx) begin
                src_valid <= 1'b0;
                src_data  <= 8'hAA;
                exp_q.push_back('{gray: 8'h00, stamp: cyc + 1});
            end else begin
                src_valid <= 1'b1;
                src_data  <= seq;
                exp_q.push_back('{gray: seq, stamp: cyc + 1});
            end
            seq <= seq + 8'd1;
        end else begin
            src_valid <= 1'b0;
            src_data  <= 8'h00;
        end
        if (!per_img_vsync) fpix <= 0;
        else if (src_rd)    fpix <= fpix + 1;
    end

    // Pipeline model: 20-cycle href delay, returning at most ret_limit pixels per frame.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe          <= '0;
            post_img_href <= 1'b0;
            ret_cnt       <= 0;
            vs_prev       <= 1'b0;
        end else begin
            pipe    <= {pipe[18:0], per_img_href};
            vs_prev <= per_img_vsync;
            if (pipe[18] && (ret_cnt < ret_limit)) begin
                post_img_href <= 1'b1;
                ret_cnt       <= ret_cnt + 1;
            end else begin
                post_img_href <= 1'b0;
            end
            if (per_img_vsync && !vs_prev) ret_cnt <= 0;
        end
    end

    // Output monitor: every href cycle pops one expected pixel and checks value and arrival cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (per_img_href || per_img_clken) begin
            check("clken_eq_href", {31'd0, per_img_clken}, {31'd0, per_img_href});
            check("vsync_during_href", {31'd0, per_img_vsync}, 32'd1);
            if (exp_q.size() == 0) begin
                check("href_without_src_rd", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("gray", {24'd0, per_img_gray}, {24'd0, exp_e.gray});
                check("href_cycle", cyc, exp_e.stamp);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Waits for the DONE pulse and checks the frame counter and vsync inside DONE.
    task automatic wait_done(input int exp_frames);
        int n;
        n = 0;
        while (!frame_done && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            check("frame_done_seen", 32'd0, 32'd1);
        end else begin
            check("frame_cnt_in_done", {16'd0, frame_cnt}, exp_frames);
            check("vsync_low_in_done", {31'd0, per_img_vsync}, 32'd0);
        end
    endtask

    // From the first href: 4 bursts of 8 pixels; the gap is HBLANK(2) plus the one WAITL cycle = 3.
    task automatic check_shape();
        int len;
        int gap;
        for (int l = 0; l < 4; l++) begin
            len = 0;
            while (per_img_href && len < 40) begin
                @(negedge clk);
                len++;
            end
            check("burst_len", len, 32'd8);
            if (l < 3) begin
                gap = 0;
                while (!per_img_href && gap < 40) begin
                    @(negedge clk);
                    gap++;
                end
                check("line_gap", gap, 32'd3);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {31'd0, busy},          32'd0);
        check({tag, "_vsync"},     {31'd0, per_img_vsync}, 32'd0);
        check({tag, "_href"},      {31'd0, per_img_href},  32'd0);
        check({tag, "_clken"},     {31'd0, per_img_clken}, 32'd0);
        check({tag, "_gray"},      {24'd0, per_img_gray},  32'd0);
        check({tag, "_src_rd"},    {31'd0, src_rd},        32'd0);
        check({tag, "_done"},      {31'd0, frame_done},    32'd0);
        check({tag, "_frame_cnt"}, {16'd0, frame_cnt},     32'd0);
        check({tag, "_uf_err"},    {31'd0, underflow_err}, 32'd0);
        check({tag, "_tmo_err"},   {31'd0, timeout_err},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  n;
        logic ok;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: basic frame. vsync rises on LEAD entry: 3 LEAD + 1 WAITL + 2 latency = 6 cycles to first href.
        pulse_start();
        check("vsync_on_lead", {31'd0, per_img_vsync}, 32'd1);
        check("busy_on_lead",  {31'd0, busy},          32'd1);
        n  = 0;
        ok = 1'b1;
        while (!per_img_href && n < 40) begin
            if (!per_img_vsync) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("vsync_to_first_href", n, 32'd6);
        check("vsync_held_in_lead", {31'd0, ok}, 32'd1);
        check_shape();
        wait_done(1);
        @(negedge clk);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("queue_empty_f1", exp_q.size(), 32'd0);

        // 2: line gating. Drop avail while line 1 is in progress; the line still completes.
        pulse_start();
        n = 0;
        while (!(src_rd && fpix == 8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        src_line_avail = 1'b0;
        n = 0;
        while (src_rd && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!per_img_vsync) ok = 1'b0;
            if (i >= 2 && (per_img_href || src_rd)) ok = 1'b0;
            if (i < 11) @(negedge clk);
        end
        check("gap_href_low_vsync_high", {31'd0, ok}, 32'd1);
        src_line_avail = 1'b1;
        @(negedge clk);
        check("src_rd_after_avail", {31'd0, src_rd}, 32'd1);
        @(negedge clk);
        check("href_not_early", {31'd0, per_img_href}, 32'd0);
        @(negedge clk);
        check("href_after_avail", {31'd0, per_img_href}, 32'd1);
        wait_done(2);
        @(negedge clk);

        // 3: underflow on pixel 5 of line 1 (frame pixel 13) emits gray 0 and sets the sticky flag.
        drop_idx = 13;
        pulse_start();
        wait_done(3);
        check("underflow_set", {31'd0, underflow_err}, 32'd1);
        check("no_timeout_f3", {31'd0, timeout_err},   32'd0);
        drop_idx = -1;
        pulse_err_clr();
        check("underflow_cleared", {31'd0, underflow_err}, 32'd0);

        // 4: only 31 pixels return; watchdog fires 64 cycles after FLUSH entry.
        ret_limit = 31;
        pulse_start();
        n = 0;
        while (per_img_vsync && n < 400) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_delay", n, 32'd64);
        check("done_with_timeout", {31'd0, frame_done}, 32'd1);
        check("frame_cnt_timeout", {16'd0, frame_cnt}, 32'd4);
        ret_limit = 32;
        @(negedge clk);
        pulse_err_clr();
        check("timeout_cleared", {31'd0, timeout_err}, 32'd0);

        // 5: continuous mode, three back-to-back frames with stray start pulses.
        cont_mode = 1'b1;
        pulse_start();
        wait_done(5);
        @(negedge clk);
        check("lead_after_done_1", {31'd0, per_img_vsync & busy}, 32'd1);
        n = 0;
        while (!src_rd && n < 40) begin
            @(negedge clk);
            n++;
        end
        pulse_start();
        wait_done(6);
        @(negedge clk);
        check("lead_after_done_2", {31'd0, per_img_vsync & busy}, 32'd1);
        pulse_start();
        cont_mode = 1'b0;
        wait_done(7);
        @(negedge clk);
        check("idle_after_cont", {31'd0, busy | per_img_vsync}, 32'd0);
        check("no_timeout_cont", {31'd0, timeout_err}, 32'd0);

        // 6: asynchronous reset during pixel 4 of line 2, then a clean frame.
        pulse_start();
        n = 0;
        while (!(src_rd && fpix == 20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        exp_q.delete();
        repeat (25) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        n = 0;
        while (!per_img_href && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_shape();
        wait_done(1);
        check("no_timeout_after_rst", {31'd0, timeout_err}, 32'd0);
        check("queue_empty_end", exp_q.size(), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
